// File: rtl/input_unit_pkg.sv
// Shared router types and constants used by the input units, switch_control
// and the crossbar.
`include "config.sv"

package input_unit_pkg;

   // Field widths of a flit.
   localparam int unsigned X_W    = 3;
   localparam int unsigned Y_W    = 3;
   localparam int unsigned DATA_W = 16;

   // Number of output ports, taken from the router configuration.
   localparam int unsigned M_PORTS = `M;

   // Output port indices into a [0:M-1] request/route vector.
   localparam logic [2:0] PORT_L = 3'd0;
   localparam logic [2:0] PORT_N = 3'd1;
   localparam logic [2:0] PORT_E = 3'd2;
   localparam logic [2:0] PORT_S = 3'd3;
   localparam logic [2:0] PORT_W = 3'd4;

   // One flit as it travels between routers.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [X_W-1:0]    x_dest;
      logic [Y_W-1:0]    y_dest;
      logic              valid;
   } packet_t;

   // One-hot output port selection, bit 0 = Local.
   typedef logic [0:M_PORTS-1] route_t;

   // FIFO slot: the flit plus its route, computed once at write time.
   typedef struct packed {
      packet_t pkt;
      route_t  route;
   } fifo_entry_t;

endpackage

// File: rtl/config.sv
// Router-wide configuration: number of input ports (N) and output ports (M).
`ifndef ROUTER_CONFIG_SV
`define ROUTER_CONFIG_SV

`define N 5
`define M 5

`endif

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X first, then Y) route computation for one flit.
// Purely combinational; also used by the local injection unit.
`include "config.sv"

module xy_route_calc
   import input_unit_pkg::*;
#(
   parameter logic [X_W-1:0] X_LOC = '0,
   parameter logic [Y_W-1:0] Y_LOC = '0
) (
   input  logic [X_W-1:0] x_dest,
   input  logic [Y_W-1:0] y_dest,
   output logic [0:`M-1]  route
);

   // Resolve X before Y; a flit at its destination leaves through Local.
   always_comb begin
      route = '0;
      if (x_dest > X_LOC) begin
         route[PORT_E] = 1'b1;
      end else if (x_dest < X_LOC) begin
         route[PORT_W] = 1'b1;
      end else if (y_dest > Y_LOC) begin
         route[PORT_N] = 1'b1;
      end else if (y_dest < Y_LOC) begin
         route[PORT_S] = 1'b1;
      end else begin
         route[PORT_L] = 1'b1;
      end
   end

endmodule

// File: rtl/input_unit.sv
// Router input port: buffers upstream flits in a small FIFO, attaches the XY
// route to each flit as it is written, and offers the head flit and its
// output request to switch_control. The head is popped on the input grant.
`include "config.sv"

module input_unit
   import input_unit_pkg::*;
#(
   parameter int unsigned     DEPTH = 4,
   parameter logic [X_W-1:0]  X_LOC = '0,
   parameter logic [Y_W-1:0]  Y_LOC = '0
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           ce,
   input  packet_t        i_data,
   output logic           o_en,
   input  logic           i_input_grant,
   output logic [0:`M-1]  o_output_req,
   output packet_t        o_data
);

   localparam int unsigned     PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = DEPTH[PTR_W:0];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;

   fifo_entry_t      mem_q [DEPTH];

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   route_t           route_in;
   fifo_entry_t      head;

   xy_route_calc #(
      .X_LOC (X_LOC),
      .Y_LOC (Y_LOC)
   ) u_route (
      .x_dest (i_data.x_dest),
      .y_dest (i_data.y_dest),
      .route  (route_in)
   );

   // Status and handshake derived only from the registered occupancy.
   always_comb begin
      full  = (count_q == FULL_CNT);
      empty = (count_q == '0);
      o_en  = !full;
      push  = ce && i_data.valid && !full;
      pop   = ce && i_input_grant && !empty;
   end

   // Pointer and occupancy next state; simultaneous push/pop keeps count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset takes priority over the clock enable.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (ce) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         mem_q[wr_ptr_q] <= '{pkt: i_data, route: route_in};
      end
   end

   // Head presentation, forced to zero when nothing is buffered.
   always_comb begin
      head = mem_q[rd_ptr_q];
      if (empty) begin
         o_data       = '0;
         o_output_req = '0;
      end else begin
         o_data       = head.pkt;
         o_output_req = head.route;
      end
   end

endmodule

// File: doc/input_unit.md
# input_unit

Per-input-port buffering and route-computation stage of the router. It sits directly upstream of `switch_control` and accepts flits from the upstream router into a FIFO. It computes the XY-routed output port for each flit as it is written, and presents the head flit's one-hot output request as one row of `switch_control`'s `i_output_req`. It pops the head flit when `switch_control` returns the matching `o_input_grant` bit.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `X_LOC`, 0, this router's X coordinate, `X_W` bits.
- `Y_LOC`, 0, this router's Y coordinate, `Y_W` bits.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `ce`  in  1  clock enable; state updates only when high.
- `i_data`  in  `packet_t`  flit from upstream: `data`, `x_dest`, `y_dest`, `valid`.
- `o_en`  out  1  to upstream: high means a flit with `i_data.valid` is accepted this cycle.
- `i_input_grant`  in  1  this port's bit of `switch_control.o_input_grant`.
- `o_output_req`  out  [0:`M-1]  one-hot requested output for the head flit; all-zero when empty.
- `o_data`  out  `packet_t`  head flit to crossbar; `valid`=0 when empty.

## Operation
Storage and pointers:
- FIFO of `DEPTH` entries; each entry holds the `packet_t` plus a precomputed `[0:`M-1]` route vector.
- Pointers `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally.
- `count` is `$clog2(DEPTH)+1` bits and is the single source for full and empty.

Push and pop:
- `push = ce && i_data.valid && o_en`.
- `pop = ce && i_input_grant && !empty`.
- `o_en = !full`. It depends only on registered `count`, with no combinational path from any input.

Route computation (combinational on `i_data`, stored at push). Port order is 0 Local, 1 North, 2 East, 3 South, 4 West; `M`=5.
- `x_dest > X_LOC` → East.
- `x_dest < X_LOC` → West.
- Otherwise `y_dest > Y_LOC` → North.
- Otherwise `y_dest < Y_LOC` → South.
- Otherwise Local.
- Comparisons are unsigned.

Outputs:
- `o_output_req` = stored route of the head entry when `!empty`, else `'0`. It is never gated by `ce`.
- `o_data` = head entry when `!empty`, else `'0`.

Boundary cases:
- **Push and pop in the same cycle:** both pointers advance and `count` is unchanged. This is legal at any non-full count, including count = 1.
- **Full:** `o_en` = 0. A valid flit presented while full is dropped. Upstream must hold it; this block does not count it.
- **Grant while empty:** ignored, with no pointer movement. The bench flags it as a protocol violation.
- **Grant while `ce` = 0:** ignored. `switch_control` is also frozen under `ce`, so its grant repeats on the next enabled cycle.
- **Reset mid-operation:** all stored flits are discarded.

## Timing
- Reset values, set one edge after `reset_n` = 0 is sampled: `wr_ptr`=0, `rd_ptr`=0, `count`=0.
  - Hence `o_en`=1, `o_output_req`='0, `o_data`='0.
  - Storage contents need no reset.
- Latency: a flit pushed at edge t appears on `o_data`/`o_output_req` after edge t (one cycle), if the FIFO was empty.
  - There is no bypass path.
- Pop: the grant is sampled at edge t. `o_data` is valid during the cycle before edge t, so the crossbar transfers it in that same cycle. The next head appears after t.
- Throughput: one push and one pop per `ce` cycle.
- `o_en` falls one edge after the push that makes `count == DEPTH`. It rises one edge after the pop from full.

## Structure
- Shared package holds the following; they are shared with `switch_control` and the crossbar:
  - `packet_t` (`data` `DATA_W`, `x_dest` `X_W`, `y_dest` `Y_W`, `valid`).
  - Port index constants `PORT_L/N/E/S/W`.
  - Widths `X_W`, `Y_W`, `DATA_W`.
- `N` and `M` come from `config.sv`.
- One sub-module: `xy_route_calc` (combinational). Parameters `X_LOC`, `Y_LOC`; inputs `x_dest`, `y_dest`; output `[0:`M-1]` one-hot route. It is reused by the local injection unit.
- The FIFO is inline in this module.

## Test plan
- **Reset:** hold `reset_n`=0 two cycles with valid input → `o_en`=1, `o_output_req`=5'b00000, `o_data.valid`=0; no flit stored.
- **Routing, `X_LOC`=1, `Y_LOC`=1:** push dests (2,1), (0,1), (1,2), (1,0), (1,1), granting each → `o_output_req` = 00100, 00001, 01000, 00010, 10000 in order.
- **Fill, `DEPTH`=4, no grant:** push 5 flits → `o_en`=0 after the 4th edge; 5th dropped. Then grant 4 cycles → flits 1–4 in order, then empty.
- **Simultaneous push/pop:** hold count=1 while granting every cycle and pushing every cycle for 20 cycles → count stays 1; the output sequence equals the input sequence with 1-cycle lag.
- **`ce` = 0 freeze:** `ce`=0 with valid push and grant for 3 cycles → pointers, `count`, `o_en`, `o_output_req` unchanged.
- **Reset mid-run:** assert `reset_n`=0 with 3 flits stored and a grant active → next cycle empty, `o_en`=1, and no spurious pop afterwards.
